// File: rtl/serial_add_ctrl_if.sv
// Handshake and operand/result bundle for the bit-serial adder sequencer.
// The requester drives start/operands; the adder returns status and result.
interface serial_add_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout
   );
endinterface

// File: rtl/fa.sv
// One-bit full adder shared by the serial adder datapath.
module fa (
   input  logic a_i,
   input  logic b_i,
   input  logic ci_i,
   output logic s_o,
   output logic co_o
);
   assign s_o  = a_i ^ b_i ^ ci_i;
   assign co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full adder, one bit per clock, LSB first,
// with a start/busy/done handshake and a registered result.
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   serial_add_ctrl_if.slave  bus
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e           state_q,  state_d;
   logic [WIDTH-1:0] a_sr_q,   a_sr_d;
   logic [WIDTH-1:0] b_sr_q,   b_sr_d;
   logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
   logic [WIDTH-1:0] sum_q,    sum_d;
   logic             carry_q,  carry_d;
   logic             cout_q,   cout_d;
   logic [CW-1:0]    count_q,  count_d;
   logic             fa_s_s;
   logic             fa_c_s;

   fa u_fa (
      .a_i  (a_sr_q[0]),
      .b_i  (b_sr_q[0]),
      .ci_i (carry_q),
      .s_o  (fa_s_s),
      .co_o (fa_c_s)
   );

   // Next-state and datapath update; the result is published on the last RUN edge
   always_comb begin
      state_d  = state_q;
      a_sr_d   = a_sr_q;
      b_sr_d   = b_sr_q;
      sum_sr_d = sum_sr_q;
      sum_d    = sum_q;
      carry_d  = carry_q;
      cout_d   = cout_q;
      count_d  = count_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               a_sr_d   = bus.a;
               b_sr_d   = bus.b;
               carry_d  = bus.cin;
               sum_sr_d = {WIDTH{1'b0}};
               count_d  = {CW{1'b0}};
               state_d  = RUN;
            end else begin
               state_d  = IDLE;
            end
         end
         RUN: begin
            a_sr_d            = {1'b0, a_sr_q[WIDTH-1:1]};
            b_sr_d            = {1'b0, b_sr_q[WIDTH-1:1]};
            carry_d           = fa_c_s;
            sum_sr_d[count_q] = fa_s_s;
            // Explicit terminal compare keeps power-of-two widths off the natural wrap
            if (count_q == LAST) begin
               count_d = {CW{1'b0}};
               sum_d   = sum_sr_d;
               cout_d  = fa_c_s;
               state_d = DONE;
            end else begin
               count_d = count_q + CW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         a_sr_q   <= {WIDTH{1'b0}};
         b_sr_q   <= {WIDTH{1'b0}};
         sum_sr_q <= {WIDTH{1'b0}};
         sum_q    <= {WIDTH{1'b0}};
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
         count_q  <= {CW{1'b0}};
      end else begin
         state_q  <= state_d;
         a_sr_q   <= a_sr_d;
         b_sr_q   <= b_sr_d;
         sum_sr_q <= sum_sr_d;
         sum_q    <= sum_d;
         carry_q  <= carry_d;
         cout_q   <= cout_d;
         count_q  <= count_d;
      end
   end

   assign bus.busy = (state_q != IDLE);
   assign bus.done = (state_q == DONE);
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomised and directed bench for serial_add_ctrl with a cycle-level
// reference model feeding a scoreboard queue checked by an independent monitor.
module tb_serial_add_ctrl;
   localparam int WIDTH = 8;

   logic             clk;
   logic             rst_n;
   bit               mon_en;
   int               checks;
   int               errors;
   int               cnt;
   logic [WIDTH:0]   mdl_hold;
   logic [WIDTH:0]   exp_q[$];
   logic [WIDTH:0]   dir_q[$];

   serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

   serial_add_ctrl #(.WIDTH(WIDTH)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [WIDTH:0] golden(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic cin);
      return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
   endfunction

   task automatic check(input string name, input logic [WIDTH:0] act, input logic [WIDTH:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: an add takes WIDTH+1 busy cycles; result becomes visible in its last one
   always @(posedge clk) begin
      if (!rst_n) begin
         cnt      <= 0;
         mdl_hold <= '0;
         exp_q.delete();
      end else if (cnt == 0) begin
         if (bus.start === 1'b1) begin
            exp_q.push_back(golden(bus.a, bus.b, bus.cin));
            cnt <= WIDTH + 1;
         end
      end else begin
         if (cnt == 2) mdl_hold <= exp_q[0];
         cnt <= cnt - 1;
      end
   end

   // Monitor: status against the model, results against the scoreboard queues
   always @(negedge clk) begin
      if (mon_en) begin
         check("busy", {{WIDTH{1'b0}}, bus.busy}, {{WIDTH{1'b0}}, (cnt != 0)});
         check("done", {{WIDTH{1'b0}}, bus.done}, {{WIDTH{1'b0}}, (cnt == 1)});
         check("hold", {bus.cout, bus.sum}, mdl_hold);
         if (bus.done === 1'b1 && exp_q.size() != 0) begin
            check("result", {bus.cout, bus.sum}, exp_q[0]);
            void'(exp_q.pop_front());
         end
         if (bus.done === 1'b1 && dir_q.size() != 0) begin
            check("directed", {bus.cout, bus.sum}, dir_q[0]);
            void'(dir_q.pop_front());
         end
      end
   end

   task automatic scramble();
      bus.a   = WIDTH'($urandom);
      bus.b   = WIDTH'($urandom);
      bus.cin = 1'($urandom);
   endtask

   task automatic do_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
      bus.start = 1'b1;
      bus.a     = a;
      bus.b     = b;
      bus.cin   = cin;
      @(posedge clk); #1;
      bus.start = 1'b0;
      scramble();
      repeat (WIDTH + 2) @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      mon_en    = 1'b0;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.cin   = 1'b0;
      repeat (2) @(posedge clk);
      #1 mon_en = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      dir_q.push_back(9'h08D); do_add(8'h5A, 8'h33, 1'b0);
      dir_q.push_back(9'h100); do_add(8'hFF, 8'h01, 1'b0);
      dir_q.push_back(9'h1FF); do_add(8'hFF, 8'hFF, 1'b1);
      dir_q.push_back(9'h001); do_add(8'h00, 8'h00, 1'b1);

      // start pulsed mid-run must be ignored
      dir_q.push_back(9'h003);
      bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h02; bus.cin = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      bus.start = 1'b1; bus.a = 8'h10;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (25) @(posedge clk);
      #1;

      // reset in the middle of a run aborts it
      bus.start = 1'b1; bus.a = 8'h55; bus.b = 8'hAA; bus.cin = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      scramble();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      dir_q.push_back(9'h080); do_add(8'h7F, 8'h01, 1'b0);

      for (int i = 0; i < 20; i++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         do_add(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
      end

      // start held high: back-to-back adds every WIDTH+2 cycles
      bus.start = 1'b1;
      for (int i = 0; i < 40; i++) begin
         scramble();
         @(posedge clk); #1;
      end
      bus.start = 1'b0;
      repeat (15) @(posedge clk);
      #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
